// File: rtl/match_timer.sv
// match_timer: match clock for the game screen.
// Counts down from START_MIN:START_SEC to 00:00, or up from 00:00 to
// START_MIN:START_SEC, and drives the four BCD digits shown by pixel_main.
// It supports pause/resume, flags the final WARN_SECS seconds of a countdown,
// and enables the buzzer for BUZZ_SECS seconds once the match has ended.
// Optional feature macro: MATCH_TIMER_WARN_BEEP_EN. When it is defined, a
// short warning beep (CLK_HZ/8 cycles) follows every tick inside the
// warning window.
module match_timer #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned START_MIN = 1,
  parameter int unsigned START_SEC = 59,
  parameter int unsigned WARN_SECS = 10,
  parameter int unsigned BUZZ_SECS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       mode_up,
  output logic [3:0] sec_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] min_1s,
  output logic [3:0] min_10s,
  output logic       tick_1Hz,
  output logic       running,
  output logic       clock_stopped,
  output logic       warn,
  output logic       buzzer_en
);

  localparam int unsigned PRESC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BUZZ_CYC = BUZZ_SECS * CLK_HZ;
  localparam int unsigned BUZZ_W   = (BUZZ_CYC > 0) ? $clog2(BUZZ_CYC + 1) : 1;

  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);

  typedef struct packed {
    logic [3:0] min_10s;
    logic [3:0] min_1s;
    logic [3:0] sec_10s;
    logic [3:0] sec_1s;
  } bcd_time_t;

  localparam bcd_time_t START_T = '{
    min_10s: 4'(START_MIN / 10),
    min_1s:  4'(START_MIN % 10),
    sec_10s: 4'(START_SEC / 10),
    sec_1s:  4'(START_SEC % 10)
  };
  localparam bcd_time_t ZERO_T = '0;

  // A zero-length match ends as soon as it is started.
  localparam bit START_IS_ZERO = (START_MIN == 0) && (START_SEC == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // BCD decrement with borrow through all four digits.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_1s != 4'd0) begin
      r.sec_1s = t.sec_1s - 4'd1;
    end else begin
      r.sec_1s = 4'd9;
      if (t.sec_10s != 4'd0) begin
        r.sec_10s = t.sec_10s - 4'd1;
      end else begin
        r.sec_10s = 4'd5;
        if (t.min_1s != 4'd0) begin
          r.min_1s = t.min_1s - 4'd1;
        end else begin
          r.min_1s  = 4'd9;
          r.min_10s = t.min_10s - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // BCD increment with carry through all four digits.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_1s != 4'd9) begin
      r.sec_1s = t.sec_1s + 4'd1;
    end else begin
      r.sec_1s = 4'd0;
      if (t.sec_10s != 4'd5) begin
        r.sec_10s = t.sec_10s + 4'd1;
      end else begin
        r.sec_10s = 4'd0;
        if (t.min_1s != 4'd9) begin
          r.min_1s = t.min_1s + 4'd1;
        end else begin
          r.min_1s  = 4'd0;
          r.min_10s = t.min_10s + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Total seconds shown by a BCD time, at most 99*60+59 = 5999.
  function automatic logic [12:0] total_secs(input bcd_time_t t);
    return 13'(t.min_10s) * 13'd600 + 13'(t.min_1s) * 13'd60 +
           13'(t.sec_10s) * 13'd10  + 13'(t.sec_1s);
  endfunction

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;      // latched mode, 1 = count-up
  bcd_time_t            time_q, time_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [BUZZ_W-1:0]    buzz_cnt_q, buzz_cnt_d;
  logic                 tick_q, tick_d;
  logic                 running_q, running_d;
  logic                 stopped_q, stopped_d;
  logic                 warn_q, warn_d;
  logic                 buzz_q, buzz_d;
  logic                 enter_done;          // this edge moves into DONE
  logic                 restart;             // this edge restarts from DONE
  logic [12:0]          total_d;

  // Match FSM, prescaler and digit stepping.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    time_d     = time_q;
    presc_d    = presc_q;
    tick_d     = 1'b0;
    enter_done = 1'b0;
    restart    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The display previews the starting value of the selected mode.
        time_d = mode_up ? ZERO_T : START_T;
        if (start) begin
          mode_d  = mode_up;
          presc_d = '0;
          if (START_IS_ZERO) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (presc_q == PRESC_TC) begin
          presc_d = '0;
          tick_d  = 1'b1;
          time_d  = mode_q ? bcd_inc(time_q) : bcd_dec(time_q);
          if (time_d == (mode_q ? START_T : ZERO_T)) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
        // A pause beats a simultaneous start; the final tick beats both.
        if (!enter_done && pause) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        // Prescaler and digits hold, keeping the partial second.
        if (start && !pause) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (start) begin
          restart = 1'b1;
          time_d  = mode_q ? ZERO_T : START_T;
          presc_d = '0;
          if (START_IS_ZERO) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MATCH_TIMER_WARN_BEEP_EN
  localparam int unsigned BEEP_CYC = CLK_HZ / 8;
  localparam int unsigned BEEP_W   = (BEEP_CYC > 0) ? $clog2(BEEP_CYC + 1) : 1;

  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

  // Warning beep: armed by each tick inside the warning window, only in RUN.
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (state_d != ST_RUN) begin
      beep_cnt_d = '0;
    end else if (tick_d && warn_d) begin
      beep_cnt_d = BEEP_W'(BEEP_CYC);
    end else if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - BEEP_W'(1);
    end
  end

  // Warning beep counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      beep_cnt_q <= '0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
    end
  end
`endif

  // Buzzer window, warning flag and next values of the registered outputs.
  always_comb begin
    buzz_cnt_d = buzz_cnt_q;
    if (enter_done) begin
      buzz_cnt_d = BUZZ_W'(BUZZ_CYC);
    end else if (restart) begin
      buzz_cnt_d = '0;
    end else if (buzz_cnt_q != '0) begin
      buzz_cnt_d = buzz_cnt_q - BUZZ_W'(1);
    end

    total_d = total_secs(time_d);
    warn_d  = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) && !mode_d &&
              (total_d != 13'd0) && (32'(total_d) <= WARN_SECS);

    running_d = (state_d == ST_RUN);
    stopped_d = (state_d == ST_DONE);

`ifdef MATCH_TIMER_WARN_BEEP_EN
    buzz_d = (buzz_cnt_d != '0) || (beep_cnt_d != '0);
`else
    buzz_d = (buzz_cnt_d != '0);
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      time_q     <= START_T;
      presc_q    <= '0;
      buzz_cnt_q <= '0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      stopped_q  <= 1'b0;
      warn_q     <= 1'b0;
      buzz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      buzz_cnt_q <= buzz_cnt_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
      stopped_q  <= stopped_d;
      warn_q     <= warn_d;
      buzz_q     <= buzz_d;
    end
  end

  assign sec_1s        = time_q.sec_1s;
  assign sec_10s       = time_q.sec_10s;
  assign min_1s        = time_q.min_1s;
  assign min_10s       = time_q.min_10s;
  assign tick_1Hz      = tick_q;
  assign running       = running_q;
  assign clock_stopped = stopped_q;
  assign warn          = warn_q;
  assign buzzer_en     = buzz_q;

endmodule

// File: doc/match_timer.md
# match_timer

Parametrised match clock for the game screen. It counts down from a configurable start time, or up to it, and drives the BCD digits shown by the pixel generator. It adds pause/resume, a final-seconds warning flag, and a timed buzzer enable. It replaces the fixed 1:59 countdown plus always-on buzzer enable, and sits between the button/FSM logic and `pixel_main`/`buzzer`.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: clk cycles per second.
- `START_MIN`, default 1: match length minutes, 0..99.
- `START_SEC`, default 59: match length seconds, 0..59.
- `WARN_SECS`, default 10: warning window length in seconds.
- `BUZZ_SECS`, default 3: buzzer duration after the match ends.

Ports:
- `clk`, in, 1: system clock, `clk_100MHz` domain.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle pulse. Meaning depends on state: begin, resume, or restart.
- `pause`, in, 1: single-cycle pulse. Freezes a running match.
- `mode_up`, in, 1: 0 = countdown, 1 = count-up. Sampled only in IDLE.
- `sec_1s`, `sec_10s`, `min_1s`, `min_10s`, out, 4 each: BCD digits.
- `tick_1Hz`, out, 1: one-cycle pulse on every digit update.
- `running`, out, 1: high in RUN.
- `clock_stopped`, out, 1: high in DONE.
- `warn`, out, 1: high during the final `WARN_SECS` seconds of a countdown.
- `buzzer_en`, out, 1: enable for `buzzer`.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE.
- **Reset:** next edge gives state IDLE. Digits = START_MIN:START_SEC. All flags are 0. Prescaler = 0. Buzz counter = 0.
- **IDLE:**
  - Each cycle, digits load START when `mode_up`=0, or 00:00 when `mode_up`=1.
  - `start` latches the mode, clears the prescaler, and moves to RUN.
- **RUN:**
  - Prescaler counts 0..CLK_HZ-1.
  - At terminal count, the digits step and `tick_1Hz` pulses.
  - `pause` moves to PAUSE. If `start` and `pause` are high together, `pause` wins.
- **PAUSE:**
  - Prescaler and digits hold, so the partial second is kept.
  - `start` returns to RUN.
  - If `start` and `pause` are high together, the block stays in PAUSE.
- **Countdown step:**
  - BCD decrement with borrow: sec_1s 0→9, sec_10s 0→5, min_1s 0→9, min_10s decrements.
  - Reaching 00:00 enters DONE on the same edge.
- **Count-up step:**
  - BCD increment with carry: sec_1s 9→0, sec_10s 5→0, min_1s 9→0.
  - Reaching START_MIN:START_SEC enters DONE on the same edge.
- **DONE:**
  - Digits hold their final value. `clock_stopped`=1.
  - `start` reloads the digits for the latched mode, clears the prescaler, and moves to RUN (restart). `pause` is ignored.
- **START = 00:00:** a countdown `start` goes straight to DONE on the next edge with no tick. The same applies to count-up.
- **warn:**
  - Asserted in RUN or PAUSE when the latched mode is countdown and 0 < min×60+sec ≤ WARN_SECS.
  - Cleared in IDLE and DONE, and in count-up mode.
- **buzzer_en:**
  - Rises on entry to DONE and stays high for exactly BUZZ_SECS×CLK_HZ cycles.
  - A restart or reset clears it immediately.
- **Widths:**
  - Prescaler width = clog2(CLK_HZ).
  - Buzz counter width = clog2(BUZZ_SECS×CLK_HZ+1).
  - The seconds total for `warn` is a 13-bit unsigned value computed from the registered digits.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- First `tick_1Hz` arrives CLK_HZ cycles after the edge that samples `start`. Subsequent ticks are exactly CLK_HZ cycles apart while in RUN.
- Digits, `tick_1Hz`, `warn`, `clock_stopped` and `buzzer_en` all update on the same edge.
- `running` changes on the edge that samples `start` or `pause`.
- Resume delay: the next tick comes (CLK_HZ − prescaler value at pause) cycles after the resume edge.
- Reset mid-operation: every output reaches its reset value on the next edge, including mid-buzz and mid-pause.

## Configuration
- Macro: `MATCH_TIMER_WARN_BEEP_EN`.
- **Defined:** while `warn`=1 and the state is RUN, `buzzer_en` is also high for the first CLK_HZ/8 cycles after each tick. The DONE buzz is unchanged.
- **Undefined:** `buzzer_en` is high only during the DONE window. No warning beeps are produced.

## Test plan
All scenarios use CLK_HZ=10.
- **Basic countdown:** START 0:03, BUZZ_SECS=3, `start` at cycle 0 → ticks at edges 10, 20 and 30 show 0:02, 0:01, 0:00. `clock_stopped` and `buzzer_en` rise at edge 30. `buzzer_en` falls at edge 60.
- **Borrow chain:** START 10:00 → first tick shows 09:59. START 1:00 → first tick shows 0:59.
- **Pause mid-second:** start, pause 4 cycles later, idle 100 cycles, then start → next tick 6 cycles after resume. Digits are unchanged during the pause.
- **Simultaneous pulses:** `start`+`pause` together in RUN → PAUSE. In PAUSE → stays in PAUSE. `start` in DONE → 0:03 reloaded, back in RUN, `buzzer_en` cleared.
- **Count-up:** `mode_up`=1, START 0:02 → digits read 00:00, 00:01, 00:02. DONE at the second tick. `warn` never asserts.
- **Warning and reset:**
  - START 0:12, WARN_SECS=10 → `warn` rises at the tick showing 0:10 and clears at 0:00.
  - With `MATCH_TIMER_WARN_BEEP_EN` defined → 1-cycle buzzer pulses after each of those ticks.
  - `reset` mid-buzz → all outputs at reset values on the next edge.
